// File: rtl/io_out_pkg.sv
// Shared constants for the IO output scheduler: FSM encoding, IO word count and default widths.
package io_out_pkg;

  localparam int unsigned IO_DATA_W    = 32;
  localparam int unsigned IO_ADDR_W    = 10;
  localparam int unsigned IO_NUM_WORDS = 21;
  localparam int unsigned IO_IDX_W     = 5;

  typedef logic [1:0] state_t;

  localparam state_t StIdle  = 2'd0;
  localparam state_t StWrite = 2'd1;
  localparam state_t StScan  = 2'd2;

  function automatic logic [IO_IDX_W-1:0] next_scan_idx(input logic [IO_IDX_W-1:0] idx,
                                                        input logic [IO_IDX_W-1:0] last_idx);
    return (idx == last_idx) ? '0 : idx + 1'b1;
  endfunction

endpackage

// File: rtl/io_scan_timer.sv
// Scan period divider: raises scan_pending once every SCAN_DIV cycles while enabled,
// cleared when the scheduler performs the scan.
module io_scan_timer #(
  parameter int unsigned SCAN_DIV = 1000
) (
  input  logic clock,
  input  logic reset_n,
  input  logic scan_en,
  input  logic scan_clear,
  output logic scan_pending
);

  localparam int unsigned DIV_W = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] LAST_DIV = DIV_W'(SCAN_DIV - 1);

  logic [DIV_W-1:0] div_q;
  logic             wrap;

  assign wrap = (div_q == LAST_DIV);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      div_q        <= '0;
      scan_pending <= 1'b0;
    end else if (!scan_en) begin
      div_q        <= '0;
      scan_pending <= 1'b0;
    end else begin
      div_q <= wrap ? '0 : div_q + 1'b1;
      // A wrap coinciding with the clearing scan starts a fresh period rather than losing it.
      if (wrap) begin
        scan_pending <= 1'b1;
      end else if (scan_clear) begin
        scan_pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/io_output_scheduler.sv
// Single owner of the IO output RAM port: arbitrates CPU stores against a periodic
// display scan, giving the CPU priority with a bounded deferral of the scan.
module io_output_scheduler
  import io_out_pkg::*;
#(
  parameter int unsigned DATA_W    = IO_DATA_W,
  parameter int unsigned ADDR_W    = IO_ADDR_W,
  parameter int unsigned NUM_WORDS = IO_NUM_WORDS,
  parameter int unsigned SCAN_DIV  = 1000,
  parameter int unsigned MAX_DEFER = 4
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                cpu_wr_req,
  input  logic [ADDR_W-1:0]   cpu_addr,
  input  logic [DATA_W-1:0]   cpu_wdata,
  output logic                cpu_wr_ack,
  output logic                ram_write,
  output logic [ADDR_W-1:0]   ram_address,
  output logic [DATA_W-1:0]   ram_dataC,
  input  logic [DATA_W-1:0]   ram_rdata,
  input  logic                scan_en,
  output logic [IO_IDX_W-1:0] disp_index,
  output logic [DATA_W-1:0]   disp_data,
  output logic                disp_valid,
  output logic                err_addr
);

  localparam int unsigned DEFER_W = $clog2(MAX_DEFER + 1);
  localparam logic [DEFER_W-1:0]  MAX_DEFER_C = DEFER_W'(MAX_DEFER);
  localparam logic [ADDR_W-1:0]   NUM_WORDS_A = ADDR_W'(NUM_WORDS);
  localparam logic [IO_IDX_W-1:0] LAST_IDX    = IO_IDX_W'(NUM_WORDS - 1);

  state_t               state_q, state_d;
  logic [IO_IDX_W-1:0]  scan_idx_q;
  logic [DEFER_W-1:0]   defer_q;
  logic                 addr_ok_q;
  logic                 scan_pending;
  logic                 scan_clear;
  logic                 grant_scan;
  logic                 grant_write;
  logic                 cpu_addr_ok;

  assign scan_clear  = (state_q == StScan);
  assign cpu_addr_ok = (cpu_addr < NUM_WORDS_A);

  io_scan_timer #(
    .SCAN_DIV (SCAN_DIV)
  ) u_scan_timer (
    .clock        (clock),
    .reset_n      (reset_n),
    .scan_en      (scan_en),
    .scan_clear   (scan_clear),
    .scan_pending (scan_pending)
  );

  always_comb begin
    grant_scan  = 1'b0;
    grant_write = 1'b0;
    state_d     = StIdle;
    if (state_q == StIdle) begin
      grant_scan  = scan_pending && (!cpu_wr_req || (defer_q == MAX_DEFER_C));
      grant_write = !grant_scan && cpu_wr_req;
      if (grant_scan) begin
        state_d = StScan;
      end else if (grant_write) begin
        state_d = StWrite;
      end
    end
  end

  // Both outputs decode the state register directly so an async reset drops them at once.
  assign cpu_wr_ack = (state_q == StWrite);
  assign ram_write  = (state_q == StWrite) && addr_ok_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      ram_address <= '0;
      ram_dataC   <= '0;
      addr_ok_q   <= 1'b0;
      err_addr    <= 1'b0;
      defer_q     <= '0;
      scan_idx_q  <= '0;
      disp_index  <= '0;
      disp_data   <= '0;
      disp_valid  <= 1'b0;
    end else begin
      state_q    <= state_d;
      disp_valid <= (state_q == StScan);
      if (grant_scan) begin
        ram_address <= ADDR_W'(scan_idx_q);
      end
      if (grant_write) begin
        ram_address <= cpu_addr;
        ram_dataC   <= cpu_wdata;
        addr_ok_q   <= cpu_addr_ok;
        err_addr    <= err_addr | !cpu_addr_ok;
      end
      if (state_q == StScan) begin
        disp_data  <= ram_rdata;
        disp_index <= scan_idx_q;
        scan_idx_q <= next_scan_idx(scan_idx_q, LAST_IDX);
        defer_q    <= '0;
      end else if (grant_write && scan_pending) begin
        defer_q <= defer_q + 1'b1;
      end else if (!scan_pending) begin
        // Pending dropped by scan_en going low; do not carry a stale count into the next scan.
        defer_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_io_output_scheduler.sv
// Self-checking bench for io_output_scheduler: directed scenarios plus a randomized run
// checked against a shadow memory and scan-order model.
module tb_io_output_scheduler;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned ADDR_W    = 10;
  localparam int unsigned NUM_WORDS = 21;
  localparam int unsigned SCAN_DIV  = 4;
  localparam int unsigned MAX_DEFER = 4;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              cpu_wr_req = 1'b0;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic [DATA_W-1:0] cpu_wdata = '0;
  logic              cpu_wr_ack;
  logic              ram_write;
  logic [ADDR_W-1:0] ram_address;
  logic [DATA_W-1:0] ram_dataC;
  logic [DATA_W-1:0] ram_rdata;
  logic              scan_en = 1'b0;
  logic [4:0]        disp_index;
  logic [DATA_W-1:0] disp_data;
  logic              disp_valid;
  logic              err_addr;

  int errors = 0;
  int checks = 0;

  logic [DATA_W-1:0] mem    [NUM_WORDS];
  logic [DATA_W-1:0] shadow [NUM_WORDS];
  logic              preload = 1'b0;

  io_output_scheduler #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .NUM_WORDS (NUM_WORDS),
    .SCAN_DIV  (SCAN_DIV),
    .MAX_DEFER (MAX_DEFER)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .cpu_wr_req  (cpu_wr_req),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_wr_ack  (cpu_wr_ack),
    .ram_write   (ram_write),
    .ram_address (ram_address),
    .ram_dataC   (ram_dataC),
    .ram_rdata   (ram_rdata),
    .scan_en     (scan_en),
    .disp_index  (disp_index),
    .disp_data   (disp_data),
    .disp_valid  (disp_valid),
    .err_addr    (err_addr)
  );

  always #5 clock = ~clock;

  // IO RAM: synchronous write, combinational read.
  always @(posedge clock) begin
    if (preload) begin
      for (int i = 0; i < NUM_WORDS; i++) mem[i] <= 32'(i + 100);
    end else if (ram_write && int'(ram_address) < NUM_WORDS) begin
      mem[ram_address[4:0]] <= ram_dataC;
    end
  end

  always_comb begin
    ram_rdata = '0;
    if (int'(ram_address) < NUM_WORDS) ram_rdata = mem[ram_address[4:0]];
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  task automatic preload_mem();
    preload = 1'b1;
    step();
    preload = 1'b0;
    for (int i = 0; i < NUM_WORDS; i++) shadow[i] = 32'(i + 100);
  endtask

  // Presents one store, waits (bounded) for its ack and reports what the RAM port showed.
  task automatic drive_store(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                             output bit acked, output int waited,
                             output logic [ADDR_W-1:0] oa, output logic [DATA_W-1:0] od,
                             output logic ow, output logic oerr);
    cpu_wr_req = 1'b1;
    cpu_addr   = a;
    cpu_wdata  = d;
    acked = 0; waited = 0; oa = '0; od = '0; ow = 1'b0; oerr = 1'b0;
    while (!acked && waited < 8) begin
      step();
      waited++;
      if (cpu_wr_ack) begin
        acked = 1; oa = ram_address; od = ram_dataC; ow = ram_write; oerr = err_addr;
      end
    end
    cpu_wr_req = 1'b0;
    if (acked && int'(a) < NUM_WORDS) shadow[a[4:0]] = d;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({ram_write, cpu_wr_ack, disp_valid, err_addr} !== 4'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 0000",
               {ram_write, cpu_wr_ack, disp_valid, err_addr});
    end
    checks++;
    if (ram_address !== '0 || ram_dataC !== '0) begin
      errors++;
      $display("FAIL reset_ram_port: got addr=%0h data=%0h expected 0/0", ram_address, ram_dataC);
    end
    checks++;
    if (disp_index !== '0 || disp_data !== '0) begin
      errors++;
      $display("FAIL reset_disp: got idx=%0d data=%0h expected 0/0", disp_index, disp_data);
    end
  endtask

  task automatic test_store();
    bit acked; int waited; logic [ADDR_W-1:0] oa; logic [DATA_W-1:0] od; logic ow, oerr;
    scan_en = 1'b0;
    drive_store(10'd5, 32'hDEADBEEF, acked, waited, oa, od, ow, oerr);
    checks++;
    if (!acked || waited != 1) begin
      errors++;
      $display("FAIL store_ack: got acked=%0d after %0d cycles expected ack after 1", acked, waited);
    end
    checks++;
    if (oa !== 10'd5 || od !== 32'hDEADBEEF || ow !== 1'b1) begin
      errors++;
      $display("FAIL store_port: got addr=%0d data=%0h write=%b expected 5 deadbeef 1", oa, od, ow);
    end
    step();
    checks++;
    if (ram_write !== 1'b0 || cpu_wr_ack !== 1'b0 || ram_address !== 10'd5) begin
      errors++;
      $display("FAIL store_one_cycle: got write=%b ack=%b addr=%0d expected 0 0 5",
               ram_write, cpu_wr_ack, ram_address);
    end
    checks++;
    if (mem[5] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL store_ram: got %0h expected deadbeef", mem[5]);
    end
  endtask

  task automatic test_bad_addr();
    bit acked; int waited; logic [ADDR_W-1:0] oa; logic [DATA_W-1:0] od; logic ow, oerr;
    drive_store(10'd21, 32'h1234, acked, waited, oa, od, ow, oerr);
    checks++;
    if (!acked || ow !== 1'b0 || oerr !== 1'b1 || oa !== 10'd21) begin
      errors++;
      $display("FAIL bad_addr_21: got ack=%0d write=%b err=%b addr=%0d expected 1 0 1 21",
               acked, ow, oerr, oa);
    end
    drive_store(10'd1023, 32'h5678, acked, waited, oa, od, ow, oerr);
    checks++;
    if (!acked || ow !== 1'b0 || oerr !== 1'b1) begin
      errors++;
      $display("FAIL bad_addr_1023: got ack=%0d write=%b err=%b expected 1 0 1", acked, ow, oerr);
    end
    for (int i = 0; i < 5; i++) step();
    checks++;
    if (err_addr !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky: got %b expected 1", err_addr);
    end
  endtask

  task automatic test_reset_mid_write();
    scan_en    = 1'b0;
    cpu_wr_req = 1'b1;
    cpu_addr   = 10'd7;
    cpu_wdata  = 32'hAAAA5555;
    step();
    checks++;
    if (ram_write !== 1'b1) begin
      errors++;
      $display("FAIL mid_write_setup: got ram_write=%b expected 1", ram_write);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({ram_write, cpu_wr_ack, disp_valid, err_addr} !== 4'b0 || ram_address !== '0 ||
        ram_dataC !== '0) begin
      errors++;
      $display("FAIL mid_write_reset: got flags=%b addr=%0h data=%0h expected 0",
               {ram_write, cpu_wr_ack, disp_valid, err_addr}, ram_address, ram_dataC);
    end
    cpu_wr_req = 1'b0;
    step();
    step();
    checks++;
    if (mem[7] !== shadow[7]) begin
      errors++;
      $display("FAIL mid_write_ram: got %0h expected %0h", mem[7], shadow[7]);
    end
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_scan_sequence();
    int cycles;
    do_reset();
    preload_mem();
    scan_en = 1'b1;
    for (int k = 0; k < NUM_WORDS + 1; k++) begin
      cycles = 0;
      do begin
        step();
        cycles++;
      end while (!disp_valid && cycles < 12);
      checks++;
      if (!disp_valid || disp_index !== 5'(k % NUM_WORDS) ||
          disp_data !== shadow[k % NUM_WORDS]) begin
        errors++;
        $display("FAIL scan_%0d: got valid=%b idx=%0d data=%0h expected 1 %0d %0h", k,
                 disp_valid, disp_index, disp_data, k % NUM_WORDS, shadow[k % NUM_WORDS]);
      end
      if (k > 0) begin
        checks++;
        if (cycles != SCAN_DIV) begin
          errors++;
          $display("FAIL scan_period_%0d: got %0d cycles expected %0d", k, cycles, SCAN_DIV);
        end
      end
    end
    scan_en = 1'b0;
    step();
  endtask

  task automatic test_defer();
    int edges, deferred;
    bit seen, resumed;
    do_reset();
    scan_en    = 1'b0;
    cpu_wr_req = 1'b1;
    cpu_addr   = 10'($urandom_range(0, NUM_WORDS - 1));
    cpu_wdata  = $urandom;
    for (int i = 0; i < 6; i++) begin
      step();
      if (cpu_wr_ack) begin
        shadow[cpu_addr[4:0]] = cpu_wdata;
        cpu_addr  = 10'($urandom_range(0, NUM_WORDS - 1));
        cpu_wdata = $urandom;
      end
    end
    scan_en = 1'b1;
    edges = 0; deferred = 0; seen = 0;
    while (!seen && edges < 30) begin
      step();
      edges++;
      if (disp_valid) seen = 1;
      if (cpu_wr_ack) begin
        // The divider wraps on the 4th edge; grants after that are made with the scan pending.
        if (edges > SCAN_DIV) deferred++;
        shadow[cpu_addr[4:0]] = cpu_wdata;
        cpu_addr  = 10'($urandom_range(0, NUM_WORDS - 1));
        cpu_wdata = $urandom;
      end
    end
    checks++;
    if (!seen || deferred != MAX_DEFER) begin
      errors++;
      $display("FAIL defer_count: got scan=%0d deferred=%0d expected 1 %0d", seen, deferred,
               MAX_DEFER);
    end
    checks++;
    if (edges > SCAN_DIV + 2 * MAX_DEFER + 3) begin
      errors++;
      $display("FAIL defer_bound: got scan at edge %0d expected <= %0d", edges,
               SCAN_DIV + 2 * MAX_DEFER + 3);
    end
    checks++;
    if (disp_index !== 5'd0 || disp_data !== shadow[0]) begin
      errors++;
      $display("FAIL defer_scan_data: got idx=%0d data=%0h expected 0 %0h", disp_index,
               disp_data, shadow[0]);
    end
    resumed = 0;
    for (int i = 0; i < 4 && !resumed; i++) begin
      step();
      if (cpu_wr_ack) begin
        resumed = 1;
        shadow[cpu_addr[4:0]] = cpu_wdata;
      end
    end
    checks++;
    if (!resumed) begin
      errors++;
      $display("FAIL defer_resume: got no ack expected an ack within 4 cycles");
    end
    cpu_wr_req = 1'b0;
    scan_en    = 1'b0;
    step();
    step();
  endtask

  task automatic test_write_then_scan();
    bit acked, found; int waited, cycles; logic [ADDR_W-1:0] oa; logic [DATA_W-1:0] od;
    logic ow, oerr;
    do_reset();
    scan_en = 1'b1;
    found = 0; cycles = 0;
    while (!found && cycles < 40) begin
      step();
      cycles++;
      if (disp_valid && disp_index == 5'd2) found = 1;
    end
    drive_store(10'd3, 32'h5, acked, waited, oa, od, ow, oerr);
    checks++;
    if (!found || !acked || waited != 1) begin
      errors++;
      $display("FAIL wscan_grant: got found=%0d ack=%0d wait=%0d expected 1 1 1", found, acked,
               waited);
    end
    cycles = 0;
    do begin
      step();
      cycles++;
    end while (!disp_valid && cycles < 8);
    checks++;
    if (!disp_valid || disp_index !== 5'd3 || disp_data !== 32'h5) begin
      errors++;
      $display("FAIL wscan_data: got valid=%b idx=%0d data=%0h expected 1 3 5", disp_valid,
               disp_index, disp_data);
    end
    scan_en = 1'b0;
    step();
  endtask

  task automatic test_random();
    bit req_active, err_exp, done;
    int wait_cnt, exp_idx, scans, bad;
    logic [ADDR_W-1:0] cur_a;
    logic [DATA_W-1:0] cur_d;
    do_reset();
    scan_en = 1'b1;
    req_active = 0; err_exp = 0; done = 0; wait_cnt = 0; exp_idx = 0; scans = 0;
    cur_a = '0; cur_d = '0;
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      step();
      checks++;
      if ((ram_write && !cpu_wr_ack) || (cpu_wr_ack && !req_active)) begin
        errors++;
        $display("FAIL rnd_spurious: got write=%b ack=%b req=%0d expected no stray strobe",
                 ram_write, cpu_wr_ack, req_active);
      end
      if (disp_valid) begin
        checks++;
        if (disp_index !== 5'(exp_idx) || disp_data !== shadow[exp_idx]) begin
          errors++;
          $display("FAIL rnd_scan: got idx=%0d data=%0h expected %0d %0h", disp_index,
                   disp_data, exp_idx, shadow[exp_idx]);
        end
        exp_idx = (exp_idx + 1) % NUM_WORDS;
        scans++;
      end
      if (req_active) begin
        wait_cnt++;
        if (cpu_wr_ack) begin
          if (int'(cur_a) >= NUM_WORDS) err_exp = 1;
          checks++;
          if (ram_address !== cur_a || ram_dataC !== cur_d ||
              ram_write !== (int'(cur_a) < NUM_WORDS) || err_addr !== err_exp || wait_cnt > 4) begin
            errors++;
            $display("FAIL rnd_store: got addr=%0d data=%0h wr=%b err=%b wait=%0d expected %0d %0h %b %b <=4",
                     ram_address, ram_dataC, ram_write, err_addr, wait_cnt, cur_a, cur_d,
                     int'(cur_a) < NUM_WORDS, err_exp);
          end
          if (int'(cur_a) < NUM_WORDS) shadow[cur_a[4:0]] = cur_d;
          req_active = 0;
          cpu_wr_req = 1'b0;
        end else if (wait_cnt > 8) begin
          errors++;
          checks++;
          $display("FAIL rnd_timeout: got no ack after %0d cycles expected <= 4", wait_cnt);
          done = 1;
        end
      end
      if (!req_active && !done && $urandom_range(0, 99) < 60) begin
        cur_a = ($urandom_range(0, 15) == 0) ? 10'($urandom_range(NUM_WORDS, 1023))
                                              : 10'($urandom_range(0, NUM_WORDS - 1));
        cur_d = $urandom;
        cpu_addr   = cur_a;
        cpu_wdata  = cur_d;
        cpu_wr_req = 1'b1;
        req_active = 1;
        wait_cnt   = 0;
      end
    end
    cpu_wr_req = 1'b0;
    scan_en    = 1'b0;
    step();
    step();
    bad = 0;
    for (int i = 0; i < NUM_WORDS; i++) if (mem[i] !== shadow[i]) bad++;
    checks++;
    if (bad != 0 || scans == 0 || err_addr !== err_exp) begin
      errors++;
      $display("FAIL rnd_final: got bad_words=%0d scans=%0d err=%b expected 0 >0 %b", bad, scans,
               err_addr, err_exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000ns");
    $fatal(1, "watchdog");
  end

  initial begin
    preload_mem();
    test_reset();
    test_store();
    test_bad_addr();
    test_reset_mid_write();
    test_scan_sequence();
    test_defer();
    test_write_then_scan();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
